gcd_ctrl_fsm: RTL

//   Control sequencer for the GCD datapath; sits directly upstream of GDCMAIN and drives its control word
//   (raddr1, raddr2, wen, waddr, wdsrc, func, constant). It consumes the datapath ALU zero flag (isZero).

---
 rtl/gcd_pkg.sv | 28 ++
 rtl/gcd_ctrl_fsm.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gcd_pkg.sv
// gcd_pkg: ALU function codes, register-file indices and sequencer states
// shared by the GCD control sequencer and anything that decodes its control word.
package gcd_pkg;

  typedef enum logic [3:0] {
    FN_ADD   = 4'd0,
    FN_SUB   = 4'd1,
    FN_SLT   = 4'd2,
    FN_PASSA = 4'd3
  } func_e;

  localparam int REG_A = 1;
  localparam int REG_B = 2;

  typedef enum logic [3:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    ZA,
    ZB,
    CHK,
    CMP,
    SUB_A,
    SUB_B,
    DONE
  } state_e;

endpackage

// File: rtl/gcd_ctrl_fsm.sv
// gcd_ctrl_fsm: Moore sequencer that drives the GCD datapath control word and
// runs subtractive Euclid on REG_A/REG_B using the ALU zero flag.
// Optional iteration cap: define GCD_TIMEOUT_EN to enable the 16-bit CMP-visit
// counter and the err flag; otherwise err is tied low and CHK only exits on zero.
module gcd_ctrl_fsm
  import gcd_pkg::*;
#(
  parameter int          DW       = 32,
  parameter int          AW       = 4,
  parameter int unsigned MAX_ITER = 65535
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [DW-1:0] a_in_i,
  input  logic [DW-1:0] b_in_i,
  input  logic          isZero_i,
  output logic [AW-1:0] raddr1_o,
  output logic [AW-1:0] raddr2_o,
  output logic          wen_o,
  output logic [AW-1:0] waddr_o,
  output logic          wdsrc_o,
  output logic [3:0]    func_o,
  output logic [DW-1:0] constant_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [AW-1:0] res_addr_o,
  output logic          err_o
);

  localparam logic [AW-1:0] RA = AW'(REG_A);
  localparam logic [AW-1:0] RB = AW'(REG_B);

  state_e        state_q, state_d;
  logic [DW-1:0] opA_q, opA_d;
  logic [DW-1:0] opB_q, opB_d;
  logic [AW-1:0] resAddr_q, resAddr_d;
  logic          timeoutHit;

  // State, captured operands and result index; reset abandons any run in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      opA_q     <= '0;
      opB_q     <= '0;
      resAddr_q <= RA;
    end else begin
      state_q   <= state_d;
      opA_q     <= opA_d;
      opB_q     <= opB_d;
      resAddr_q <= resAddr_d;
    end
  end

`ifdef GCD_TIMEOUT_EN
  localparam logic [15:0] MAX_ITER_W = 16'(MAX_ITER);

  logic [15:0] iterCnt_q, iterCnt_d;
  logic        err_q, err_d;

  assign timeoutHit = (iterCnt_q == MAX_ITER_W);

  // Counter restarts in IDLE and counts CMP visits; err latches when CHK gives up.
  always_comb begin
    iterCnt_d = iterCnt_q;
    err_d     = err_q;
    if (state_q == IDLE) begin
      iterCnt_d = '0;
      err_d     = 1'b0;
    end else begin
      if (state_q == CMP) begin
        iterCnt_d = iterCnt_q + 16'd1;
      end
      if ((state_q == CHK) && !isZero_i && timeoutHit) begin
        err_d = 1'b1;
      end
    end
  end

  // Iteration counter and timeout flag registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      iterCnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      iterCnt_q <= iterCnt_d;
      err_q     <= err_d;
    end
  end

  assign err_o = (state_q == DONE) && err_q;
`else
  logic unusedMaxIter;

  assign unusedMaxIter = (MAX_ITER != 0);
  assign timeoutHit    = 1'b0;
  assign err_o         = 1'b0;
`endif

  // Next-state selection plus the Moore decode of the datapath control word.
  always_comb begin
    state_d    = state_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    resAddr_d  = resAddr_q;
    raddr1_o   = RA;
    raddr2_o   = RB;
    wen_o      = 1'b0;
    waddr_o    = '0;
    wdsrc_o    = 1'b0;
    func_o     = FN_ADD;
    constant_o = '0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    res_addr_o = RA;
    case (state_q)
      IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          opA_d   = a_in_i;
          opB_d   = b_in_i;
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        wen_o      = 1'b1;
        waddr_o    = RA;
        wdsrc_o    = 1'b1;
        constant_o = opA_q;
        state_d    = LOAD_B;
      end
      LOAD_B: begin
        wen_o      = 1'b1;
        waddr_o    = RB;
        wdsrc_o    = 1'b1;
        constant_o = opB_q;
        state_d    = ZA;
      end
      ZA: begin
        func_o = FN_PASSA;
        if (isZero_i) begin
          resAddr_d = RB;
          state_d   = DONE;
        end else begin
          state_d = ZB;
        end
      end
      ZB: begin
        func_o   = FN_PASSA;
        raddr1_o = RB;
        if (isZero_i) begin
          resAddr_d = RA;
          state_d   = DONE;
        end else begin
          state_d = CHK;
        end
      end
      CHK: begin
        func_o = FN_SUB;
        if (isZero_i || timeoutHit) begin
          resAddr_d = RA;
          state_d   = DONE;
        end else begin
          state_d = CMP;
        end
      end
      CMP: begin
        func_o  = FN_SLT;
        state_d = isZero_i ? SUB_A : SUB_B;
      end
      SUB_A: begin
        func_o  = FN_SUB;
        wen_o   = 1'b1;
        waddr_o = RA;
        state_d = CHK;
      end
      SUB_B: begin
        func_o   = FN_SUB;
        raddr1_o = RB;
        raddr2_o = RA;
        wen_o    = 1'b1;
        waddr_o  = RB;
        state_d  = CHK;
      end
      DONE: begin
        done_o     = 1'b1;
        raddr1_o   = resAddr_q;
        res_addr_o = resAddr_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
